// File: rtl/ps2_key_tx.sv
// ps2_key_tx
// Serialises ps2_key events into PS/2 device-to-host frames. Events are
// queued in a small FIFO. Each event expands to a 1-3 byte Set-2 sequence:
// an optional E0 prefix, an optional F0 break marker, then the code.
// Host clock inhibit aborts the current byte, which is then resent whole.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   ps2_key       [10] strobe, [9] pressed, [8] extended, [7:0] code
//   ps2_clk_in    sensed PS/2 clock line (asynchronous)
//   ps2_clk_out   clock drive (0 pulls low, 1 releases)
//   ps2_data_out  data drive (0 pulls low, 1 releases)
//   busy          FIFO non-empty or FSM active
//   overflow      sticky, an event was dropped on a full FIFO
module ps2_key_tx #(
  parameter int CLK_DIV    = 1500,
  parameter int GAP_CYCLES = 3000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic        ps2_clk_in,
  output logic        ps2_clk_out,
  output logic        ps2_data_out,
  output logic        busy,
  output logic        overflow
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int MAXC = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] SYNC_SETTLE = CW'(2);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_LINE, S_BIT_HIGH, S_BIT_LOW, S_GAP
  } state_t;

  // Clock line synchroniser
  logic clk_meta_q, clk_s_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_meta_q <= 1'b1;
      clk_s_q    <= 1'b1;
    end else begin
      clk_meta_q <= ps2_clk_in;
      clk_s_q    <= clk_meta_q;
    end
  end

  // Event FIFO; pointers carry one extra wrap bit to tell full from empty
  logic [9:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        overflow_q;
  logic        fifo_empty, fifo_full, push, pop, accept;
  logic [9:0]  fifo_rd_data;
  state_t      state_q, state_d;

  assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
  assign fifo_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push         = ps2_key[10] && (ps2_key[8:0] != 9'd0);
  assign pop          = (state_q == S_IDLE) && !fifo_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign accept       = push && (!fifo_full || pop);
  assign fifo_rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q[AW-1:0]] <= ps2_key[9:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !accept) overflow_q <= 1'b1;
    end
  end

  // Transmit FSM
  logic [9:0]    event_q, event_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [10:0]   frame_q, frame_d;
  logic [7:0]    cur_byte;
  logic [1:0]    last_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      event_q    <= '0;
      byte_idx_q <= '0;
      bitcnt_q   <= '0;
      cnt_q      <= '0;
      frame_q    <= '1;
    end else begin
      state_q    <= state_d;
      event_q    <= event_d;
      byte_idx_q <= byte_idx_d;
      bitcnt_q   <= bitcnt_d;
      cnt_q      <= cnt_d;
      frame_q    <= frame_d;
    end
  end

  // Byte selection within the sequence: [E0], [F0], code
  always_comb begin
    cur_byte = event_q[7:0];
    if (event_q[8] && byte_idx_q == 2'd0)
      cur_byte = 8'hE0;
    else if (!event_q[9] && byte_idx_q == {1'b0, event_q[8]})
      cur_byte = 8'hF0;
    last_idx = {1'b0, event_q[8]} + {1'b0, ~event_q[9]};
  end

  always_comb begin
    state_d      = state_q;
    event_d      = event_q;
    byte_idx_d   = byte_idx_q;
    bitcnt_d     = bitcnt_q;
    cnt_d        = cnt_q;
    frame_d      = frame_q;
    ps2_clk_out  = 1'b1;
    ps2_data_out = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          event_d    = fifo_rd_data;
          byte_idx_d = 2'd0;
          state_d    = S_WAIT_LINE;
        end
      end
      S_WAIT_LINE: begin
        if (clk_s_q) begin
          // start 0, data LSB first, odd parity, stop 1
          frame_d  = {1'b1, ~^cur_byte, cur_byte, 1'b0};
          bitcnt_d = 4'd0;
          cnt_d    = '0;
          state_d  = S_BIT_HIGH;
        end
      end
      S_BIT_HIGH: begin
        ps2_data_out = frame_q[bitcnt_q];
        // The first two phases still see our own low phase through the
        // synchroniser, so inhibit is only trusted from phase 2 onwards.
        if (!clk_s_q && cnt_q >= SYNC_SETTLE) begin
          cnt_d   = '0;
          state_d = S_WAIT_LINE;
        end else if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          state_d = S_BIT_LOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BIT_LOW: begin
        ps2_clk_out  = 1'b0;
        ps2_data_out = frame_q[bitcnt_q];
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (bitcnt_q == 4'd10) begin
            state_d = S_GAP;
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
            state_d  = S_BIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (byte_idx_q == last_idx) begin
            state_d = S_IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
            state_d    = S_WAIT_LINE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = !fifo_empty || (state_q != S_IDLE);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ps2_key_tx.sv
// Testbench for ps2_key_tx: a PS/2 host model receives frames on falling
// clock edges and checks them against a scoreboard of expected bytes.
module tb_ps2_key_tx;
  localparam int CLK_DIV = 4;
  localparam int GAP     = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] ps2_key = '0;
  logic        host_clk = 1'b1;
  logic        ps2_clk_in;
  logic        ps2_clk_out, ps2_data_out, busy, overflow;

  assign ps2_clk_in = host_clk & ps2_clk_out;

  ps2_key_tx #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .ps2_key(ps2_key), .ps2_clk_in(ps2_clk_in),
    .ps2_clk_out(ps2_clk_out), .ps2_data_out(ps2_data_out),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] exp_q[$];

  task automatic push_event(input logic [9:0] ev);
    if (ev[8]) exp_q.push_back(8'hE0);
    if (!ev[9]) exp_q.push_back(8'hF0);
    exp_q.push_back(ev[7:0]);
  endtask

  // Host receiver
  logic [10:0] rx_frame = '0;
  logic [10:0] last_frame = '0;
  int rx_bits = 0, rx_frames = 0, first_fall = 0, rel_run = 0, fall_count = 0;
  logic prev_clk = 1'b1, prev_data = 1'b1;

  always @(negedge clk) begin
    logic [7:0]  b;
    logic [11:0] expf;
    if (prev_clk && !ps2_clk_out) fall_count++;
    if (reset || !host_clk) begin
      rx_bits = 0;
    end else if (prev_clk && !ps2_clk_out) begin
      rx_frame[rx_bits] = ps2_data_out;
      if (rx_bits == 0) first_fall = cyc;
      rx_bits++;
      if (rx_bits == 11) begin
        check("frame_len", 32'(cyc - first_fall), 32'(20 * CLK_DIV));
        if (exp_q.size() > 0) begin
          b = exp_q.pop_front();
          expf = {1'b0, 1'b1, ~^b, b, 1'b0};
        end else begin
          expf = 12'hFFF;
        end
        check("frame", 32'({1'b0, rx_frame}), 32'(expf));
        $display("frame %0d: data %02h parity %0d at cycle %0d",
                 rx_frames, rx_frame[8:1], rx_frame[9], cyc);
        last_frame = rx_frame;
        rx_frames++;
        rx_bits = 0;
      end
    end
    if (ps2_clk_out && ps2_data_out) begin
      rel_run++;
    end else begin
      if (ps2_clk_out && prev_data && !ps2_data_out && rx_bits == 0 && !reset)
        check("gap_released", 32'((rel_run >= GAP + 1) ? GAP + 1 : rel_run), 32'(GAP + 1));
      rel_run = 0;
    end
    prev_clk  = ps2_clk_out;
    prev_data = ps2_data_out;
  end

  task automatic pulse_key(input logic [10:0] k);
    @(posedge clk); #1 ps2_key = k;
    @(posedge clk); #1 ps2_key = '0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    int base, f0, bad, n;
    logic [8:0] ovf_codes [6];
    ovf_codes = '{9'h016, 9'h018, 9'h01A, 9'h01E, 9'h022, 9'h026};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_clk", 32'(ps2_clk_out), 32'd1);
    check("rst_data", 32'(ps2_data_out), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    repeat (4) @(posedge clk);

    // Make 29: exact latency and busy timing
    @(posedge clk); #1 ps2_key = {2'b11, 9'h029};
    push_event(10'h229);
    @(posedge clk); #1 ps2_key = '0;
    check("lat_busy_t1", 32'(busy), 32'd1);
    check("lat_data_t1", 32'(ps2_data_out), 32'd1);
    @(posedge clk); #1;
    check("lat_data_t2", 32'(ps2_data_out), 32'd1);
    @(posedge clk); #1;
    check("lat_start_t3", 32'(ps2_data_out), 32'd0);
    repeat (95) @(posedge clk);
    #1;
    check("busy_gap_end", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("busy_fall", 32'(busy), 32'd0);
    check("mk29_bits", 32'(last_frame), 32'h452);
    check("mk29_q", 32'(exp_q.size()), 32'd0);

    // Extended break 175: E0 F0 75
    base = rx_frames;
    pulse_key({2'b10, 9'h175});
    push_event(10'h175);
    wait_idle("brk_idle", 2000);
    check("brk_frames", 32'(rx_frames - base), 32'd3);
    check("brk_q", 32'(exp_q.size()), 32'd0);

    // Inhibit before the frame, then during bit 5
    base = rx_frames;
    host_clk = 1'b0;
    f0 = fall_count;
    pulse_key({2'b11, 9'h01C});
    push_event(10'h21C);
    repeat (30) @(posedge clk);
    #1;
    check("inh_no_falls", 32'(fall_count - f0), 32'd0);
    check("inh_data_rel", 32'(ps2_data_out), 32'd1);
    check("inh_busy", 32'(busy), 32'd1);
    host_clk = 1'b1;
    n = 0;
    while (!(rx_bits == 5 && ps2_clk_out) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("bit5_reach", 32'(n < 400), 32'd1);
    host_clk = 1'b0;
    repeat (4) @(posedge clk);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!ps2_clk_out || !ps2_data_out) bad++;
      @(posedge clk);
    end
    check("inh_abort_release", 32'(bad), 32'd0);
    #1 host_clk = 1'b1;
    wait_idle("inh_idle", 2000);
    check("inh_frames", 32'(rx_frames - base), 32'd1);
    check("inh_q", 32'(exp_q.size()), 32'd0);

    // Overflow: 6 strobes while inhibited, 5 accepted
    base = rx_frames;
    host_clk = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pulse_key({2'b11, ovf_codes[i]});
      if (i < 5) push_event({1'b1, ovf_codes[i]});
    end
    #1;
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_busy", 32'(busy), 32'd1);
    host_clk = 1'b1;
    wait_idle("ovf_idle", 5000);
    check("ovf_frames", 32'(rx_frames - base), 32'd5);
    check("ovf_q", 32'(exp_q.size()), 32'd0);

    // Reset during byte 2 of an extended break
    base = rx_frames;
    pulse_key({2'b10, 9'h175});
    push_event(10'h175);
    n = 0;
    while (!(rx_frames == base + 1 && rx_bits >= 3) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("rstmid_reach", 32'(n < 1000), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rstmid_clk", 32'(ps2_clk_out), 32'd1);
    check("rstmid_data", 32'(ps2_data_out), 32'd1);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    exp_q.delete();
    base = rx_frames;
    f0 = fall_count;
    repeat (300) @(posedge clk);
    #1;
    check("rstmid_no_falls", 32'(fall_count - f0), 32'd0);
    check("rstmid_no_frames", 32'(rx_frames - base), 32'd0);
    check("rstmid_busy_after", 32'(busy), 32'd0);

    // Zero scancode is ignored
    f0 = fall_count;
    pulse_key(11'h400);
    #1 check("zero_busy_a", 32'(busy), 32'd0);
    pulse_key(11'h600);
    #1 check("zero_busy_b", 32'(busy), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("zero_no_falls", 32'(fall_count - f0), 32'd0);
    check("zero_ovf", 32'(overflow), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
